// File: rtl/dec_scan_if.sv
// Handshake and control bundle between a scan controller and dec_scan_sequencer.
// The mask signal exists only when DEC_SCAN_MASK_EN is defined.
interface dec_scan_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode_cont;
  logic [DWELL_W-1:0] dwell;
`ifdef DEC_SCAN_MASK_EN
  logic [7:0]         mask;
`endif
  logic [2:0]         code;
  logic               valid;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode_cont, dwell,
`ifdef DEC_SCAN_MASK_EN
    output mask,
`endif
    input  code, valid, busy, done
  );

  modport slave (
    input  start, stop, mode_cont, dwell,
`ifdef DEC_SCAN_MASK_EN
    input  mask,
`endif
    output code, valid, busy, done
  );
endinterface

// File: rtl/dec_scan_sequencer.sv
// Registered scan sequencer producing the 3-bit select code for a 3-to-8 decoder.
// Define DEC_SCAN_MASK_EN to add per-index channel masking (mask port on the interface).
module dec_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  dec_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         code_q,  code_d;
  logic               valid_q, valid_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [DWELL_W-1:0] cnt_q,   cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q,  mode_d;

  logic [7:0] start_mask;
  logic [7:0] scan_mask;

`ifdef DEC_SCAN_MASK_EN
  logic [7:0] mask_q, mask_d;
  assign start_mask = bus.mask;
  assign scan_mask  = mask_q;
`else
  assign start_mask = 8'hFF;
  assign scan_mask  = 8'hFF;
`endif

  // Lowest enabled index; 0 when nothing is enabled.
  function automatic logic [2:0] first_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest enabled index strictly above cur.
  function automatic logic [3:0] next_idx(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > cur)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [3:0] nxt;
  assign nxt = next_idx(scan_mask, code_q);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
`ifdef DEC_SCAN_MASK_EN
    mask_d  = mask_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          dwell_d = bus.dwell;
          mode_d  = bus.mode_cont;
`ifdef DEC_SCAN_MASK_EN
          mask_d  = bus.mask;
`endif
          cnt_d   = '0;
          if (start_mask == 8'h00) begin
            // Empty scan: report completion without ever asserting valid.
            state_d = ST_DONE;
            done_d  = 1'b1;
            code_d  = 3'd0;
          end else begin
            state_d = ST_RUN;
            code_d  = first_idx(start_mask);
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          code_d  = 3'd0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (nxt[3]) begin
            code_d = nxt[2:0];
          end else if (mode_q) begin
            code_d = first_idx(scan_mask);
          end else begin
            state_d = ST_DONE;
            code_d  = 3'd0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        code_d  = 3'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
`ifdef DEC_SCAN_MASK_EN
      mask_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
`ifdef DEC_SCAN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
